tty_writer: RTL and testbench
=============================

// Module: tty_writer
// PURPOSE
//  Character-stream writer for the 80x25 text buffer that the ga video adapter
//  scans out of comm (window 0xF000-0xFFFF).
//  Accepts bytes over a valid/ready handshake, interprets control codes and
//  writes char/attribute pairs at a hardware cursor.
//  Scrolls the screen by copying rows inside the buffer. Drives the comm
//  port-x bus (ax/qx/dx/wx) in the clock_25 domain.
// PARAMETERS
//  BASE      16'hF000  byte address of cell (0,0)
//  COLS      80        columns per row
//  ROWS      25        rows per screen
//  BLANK     8'h20     fill character for clear and scroll
//  CLR_RST   1         1 = clear the screen after reset
// PORTS
//  clock     in   1   25 MHz system clock
//  reset_n   in   1   asynchronous reset, active low
//  in_data   in   8   character or control byte
//  in_valid  in   1   in_data valid
//  in_ready  out  1   block can accept a byte this cycle
//  attr      in   8   attribute; sampled with in_data, and at clear/fill start
//  address   out  16  memory byte address
//  data_i    in   8   memory read data; valid 1 cycle after address is set
//  data_o    out  8   memory write data
//  we        out  1   write strobe, one cycle per byte
//  cur_x     out  7   cursor column, 0..COLS-1
//  cur_y     out  5   cursor row, 0..ROWS-1
//  busy      out  1   FSM not in IDLE
// BEHAVIOUR
//  Reset values: address=BASE, data_o=0, we=0, in_ready=0, cur_x=0, cur_y=0.
//   After reset the FSM is in CLR if CLR_RST=1, otherwise in IDLE.
//  Cell layout: n = y*COLS + x. Char byte is at BASE+2n, attribute byte at BASE+2n+1.
//   Address arithmetic is 16-bit.
//  Handshake: in_ready=1 only in IDLE. A byte is taken on in_valid&&in_ready;
//   attr is latched in the same cycle. in_ready is 0 from the next cycle.
//  The FSM only leaves IDLE by taking a byte; with no byte taken it stays in IDLE.
//  Byte handling:
//   0x0D CR: x=0. Back to IDLE next cycle.
//   0x0A LF: if y<ROWS-1, y+1 and IDLE. Else go to SCROLL; y stays ROWS-1.
//   0x08 BS: if x>0, x-1. No erase.
//   0x0C FF: go to CLR; cursor becomes (0,0) when CLR ends.
//   Any other byte is printable:
//    PUT_C: address=cell char byte, data_o=char, we=1.
//    PUT_A: address+1, data_o=attr, we=1.
//    Then advance the cursor. If x<COLS-1, x+1. Else x=0 and apply the LF rule.
//    Cost: 3 cycles from accept to in_ready=1 when no scroll follows.
//  States: CLR, IDLE, PUT_C, PUT_A, SCR_RD, SCR_WT, SCR_WR, FILL_C, FILL_A.
//  CLR: 2*COLS*ROWS writes, one per cycle, alternating BLANK and attr.
//   Order is ascending from BASE. Then cursor=(0,0) and IDLE.
//  SCROLL: for i = 0 .. 2*COLS*(ROWS-1)-1, ascending:
//   SCR_RD: address = BASE+2*COLS+i, we=0.
//   SCR_WT: wait one cycle.
//   SCR_WR: address = BASE+i, data_o=data_i, we=1.
//   Then FILL_C/FILL_A write BLANK/attr over the last row, 2*COLS writes.
//   Cursor afterwards is (0, ROWS-1).
//   Ascending order keeps a source byte from being overwritten before it is read.
//  we is a single-cycle pulse. address and data_o are stable in any cycle with we=1.
//  Boundaries:
//   Wrap at (COLS-1, ROWS-1) scrolls exactly once.
//   BS at x=0 does nothing.
//   LF on the last row always scrolls.
//   Reset in any state aborts the operation at once. Outputs go to reset values,
//   and CLR restarts when CLR_RST=1.
//  Counters: cell/byte index 12 bits, compared against the full byte count.
// TESTING
//  1 Reset with CLR_RST=1 -> exactly 4000 we pulses, F000..FF9F alternating 20/attr;
//    in_ready=1 after them; cursor (0,0).
//  2 Send 0x41, attr=0x1E -> writes F000=41, then F001=1E; cur_x=1;
//    in_ready low exactly 3 cycles.
//  3 At x=5,y=3 send 0x08, 0x0D, 0x0A -> cursor (4,3), then (0,3), then (0,4);
//    no we pulses.
//  4 Preload row 1 with 'B'. At (79,24) print 'Z' ->
//    Z written at F000+2*1999 before the scroll.
//    After the scroll: F000='B', row 24 all 20/attr, cursor (0,24), 3840 copies.
//  5 Hold in_valid=1 through a scroll -> no byte is accepted until IDLE;
//    next byte lands at (0,24).
//  6 Assert reset_n=0 mid-scroll for 1 cycle -> we=0 at once, address=F000;
//    CLR reruns fully; cursor (0,0).

Source files
------------

// File: rtl/tty_writer_if.sv
// Byte-stream and memory-port bundle for tty_writer.
// The slave modport is the writer side: it accepts the byte stream and
// drives the memory port. The master modport is the opposite side.
interface tty_writer_if;
  // Byte stream.
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  attr;
  // Memory port.
  logic [15:0] address;
  logic [7:0]  data_i;
  logic [7:0]  data_o;
  logic        we;

  modport slave (
    input  in_data, in_valid, attr, data_i,
    output in_ready, address, data_o, we
  );

  modport master (
    output in_data, in_valid, attr, data_i,
    input  in_ready, address, data_o, we
  );
endinterface

// File: rtl/tty_writer.sv
// Character-stream writer for an 80x25 char/attribute text buffer.
// Takes bytes over valid/ready, handles CR/LF/BS/FF, writes printable
// characters at a hardware cursor and scrolls by copying rows in place.
// Memory-port outputs and in_ready are registered from the current state,
// so every bus action appears one cycle after the state that issues it.
module tty_writer #(
  parameter logic [15:0] BASE    = 16'hF000,
  parameter int unsigned COLS    = 80,
  parameter int unsigned ROWS    = 25,
  parameter logic [7:0]  BLANK   = 8'h20,
  parameter bit          CLR_RST = 1'b1
) (
  input  logic         clock,
  input  logic         reset_n,
  tty_writer_if.slave  bus,
  output logic [6:0]   cur_x,
  output logic [4:0]   cur_y,
  output logic         busy
);

  typedef enum logic [3:0] {
    StClr, StIdle, StPutC, StPutA, StScrRd, StScrWt, StScrWr, StFillC, StFillA
  } state_e;

  localparam state_e      ResetState = CLR_RST ? StClr : StIdle;
  localparam logic [11:0] ScreenLast = 12'(2 * COLS * ROWS - 1);
  localparam logic [11:0] CopyLast   = 12'(2 * COLS * (ROWS - 1) - 1);
  localparam logic [11:0] RowLast    = 12'(2 * COLS - 1);
  localparam logic [15:0] RowBytes   = 16'(2 * COLS);
  localparam logic [15:0] LastRowOff = 16'(2 * COLS * (ROWS - 1));
  localparam logic [6:0]  XLast      = 7'(COLS - 1);
  localparam logic [4:0]  YLast      = 5'(ROWS - 1);

  state_e      state_q, state_d;
  logic [11:0] idx_q, idx_d;
  logic [6:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic [7:0]  char_q, char_d;
  logic [7:0]  attr_q, attr_d;
  logic [15:0] address_q, address_d;
  logic [7:0]  data_q, data_d;
  logic        we_q, we_d;
  logic        ready_q, ready_d;

  logic        take;
  logic [15:0] cell_addr;

  // in_ready is only ever high while the FSM sits in IDLE.
  assign take      = bus.in_valid && ready_q && (state_q == StIdle);
  assign cell_addr = BASE + ((16'(y_q) * 16'(COLS) + 16'(x_q)) << 1);

  // Next-state, cursor and registered bus outputs.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    x_d       = x_q;
    y_d       = y_q;
    char_d    = char_q;
    attr_d    = attr_q;
    address_d = address_q;
    data_d    = data_q;
    we_d      = 1'b0;
    ready_d   = 1'b0;

    unique case (state_q)
      StClr: begin
        address_d = BASE + 16'(idx_q);
        data_d    = idx_q[0] ? attr_q : BLANK;
        we_d      = 1'b1;
        // Cell 0 writes BLANK, so attr can be latched here for the odd bytes.
        if (idx_q == 12'd0) attr_d = bus.attr;
        idx_d = idx_q + 12'd1;
        if (idx_q == ScreenLast) begin
          idx_d   = 12'd0;
          x_d     = 7'd0;
          y_d     = 5'd0;
          state_d = StIdle;
        end
      end

      StIdle: begin
        ready_d = !take;
        if (take) begin
          attr_d = bus.attr;
          char_d = bus.in_data;
          case (bus.in_data)
            8'h0D: x_d = 7'd0;
            8'h0A: begin
              if (y_q != YLast) begin
                y_d = y_q + 5'd1;
              end else begin
                idx_d   = 12'd0;
                state_d = StScrRd;
              end
            end
            8'h08: if (x_q != 7'd0) x_d = x_q - 7'd1;
            8'h0C: begin
              idx_d   = 12'd0;
              state_d = StClr;
            end
            default: state_d = StPutC;
          endcase
        end
      end

      StPutC: begin
        address_d = cell_addr;
        data_d    = char_q;
        we_d      = 1'b1;
        state_d   = StPutA;
      end

      StPutA: begin
        address_d = cell_addr + 16'd1;
        data_d    = attr_q;
        we_d      = 1'b1;
        state_d   = StIdle;
        if (x_q != XLast) begin
          x_d = x_q + 7'd1;
        end else begin
          x_d = 7'd0;
          if (y_q != YLast) begin
            y_d = y_q + 5'd1;
          end else begin
            idx_d   = 12'd0;
            state_d = StScrRd;
          end
        end
      end

      StScrRd: begin
        address_d = BASE + RowBytes + 16'(idx_q);
        state_d   = StScrWt;
      end

      // Read data returns one cycle after the address is on the bus.
      StScrWt: state_d = StScrWr;

      StScrWr: begin
        address_d = BASE + 16'(idx_q);
        data_d    = bus.data_i;
        we_d      = 1'b1;
        if (idx_q == CopyLast) begin
          idx_d   = 12'd0;
          state_d = StFillC;
        end else begin
          idx_d   = idx_q + 12'd1;
          state_d = StScrRd;
        end
      end

      StFillC: begin
        address_d = BASE + LastRowOff + 16'(idx_q);
        data_d    = BLANK;
        we_d      = 1'b1;
        if (idx_q == 12'd0) attr_d = bus.attr;
        idx_d   = idx_q + 12'd1;
        state_d = StFillA;
      end

      StFillA: begin
        address_d = BASE + LastRowOff + 16'(idx_q);
        data_d    = attr_q;
        we_d      = 1'b1;
        if (idx_q == RowLast) begin
          idx_d   = 12'd0;
          x_d     = 7'd0;
          y_d     = YLast;
          state_d = StIdle;
        end else begin
          idx_d   = idx_q + 12'd1;
          state_d = StFillC;
        end
      end

      default: state_d = ResetState;
    endcase
  end

  // State, cursor and output registers; reset aborts any operation at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ResetState;
      idx_q     <= 12'd0;
      x_q       <= 7'd0;
      y_q       <= 5'd0;
      char_q    <= 8'h00;
      attr_q    <= 8'h00;
      address_q <= BASE;
      data_q    <= 8'h00;
      we_q      <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      x_q       <= x_d;
      y_q       <= y_d;
      char_q    <= char_d;
      attr_q    <= attr_d;
      address_q <= address_d;
      data_q    <= data_d;
      we_q      <= we_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.address  = address_q;
  assign bus.data_o   = data_q;
  assign bus.we       = we_q;
  assign bus.in_ready = ready_q;
  assign cur_x        = x_q;
  assign cur_y        = y_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_tty_writer.sv
// Self-checking bench for tty_writer: a memory model behind the port, a
// write logger, and a screen/cursor reference model updated per byte.
`timescale 1ns/1ps
module tb_tty_writer;

  localparam int Cols  = 80;
  localparam int Rows  = 25;
  localparam int Cells = Cols * Rows;
  localparam int Bytes = 2 * Cells;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] cur_x;
  logic [4:0] cur_y;
  logic       busy;

  tty_writer_if bus ();

  tty_writer u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .cur_x   (cur_x),
    .cur_y   (cur_y),
    .busy    (busy)
  );

  always #20 clock = ~clock;

  // Memory behind the port plus a log of every write strobe.
  logic [7:0]  mem [0:65535];
  logic [23:0] wr_q [$];
  int          n_take = 0;

  always @(posedge clock) begin
    if (bus.we) begin
      mem[bus.address] <= bus.data_o;
      wr_q.push_back({bus.address, bus.data_o});
    end
    bus.data_i <= mem[bus.address];
    if (bus.in_valid && bus.in_ready) n_take <= n_take + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: screen image as a byte array plus cursor.
  logic [7:0] ref_mem [0:Bytes-1];
  int mx = 0;
  int my = 0;

  task automatic model_clear(input logic [7:0] a);
    for (int i = 0; i < Bytes; i++) ref_mem[i] = (i % 2 == 1) ? a : 8'h20;
    mx = 0;
    my = 0;
  endtask

  task automatic model_scroll(input logic [7:0] a);
    for (int i = 0; i < Bytes - 2 * Cols; i++) ref_mem[i] = ref_mem[i + 2 * Cols];
    for (int i = Bytes - 2 * Cols; i < Bytes; i++) ref_mem[i] = (i % 2 == 1) ? a : 8'h20;
    mx = 0;
    my = Rows - 1;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic [7:0] a);
    case (b)
      8'h0D: mx = 0;
      8'h0A: if (my < Rows - 1) my++; else model_scroll(a);
      8'h08: if (mx > 0) mx--;
      8'h0C: model_clear(a);
      default: begin
        ref_mem[2 * (my * Cols + mx)]     = b;
        ref_mem[2 * (my * Cols + mx) + 1] = a;
        if (mx < Cols - 1) begin
          mx++;
        end else begin
          mx = 0;
          if (my < Rows - 1) my++; else model_scroll(a);
        end
      end
    endcase
  endtask

  task automatic check_screen(input string tag);
    int bad = 0;
    for (int i = 0; i < Bytes; i++) if (mem[16'hF000 + i] !== ref_mem[i]) bad++;
    check_eq(tag, bad, 0);
  endtask

  task automatic check_cursor(input string tag);
    check_eq({tag, "_x"}, 32'(cur_x), mx);
    check_eq({tag, "_y"}, 32'(cur_y), my);
  endtask

  task automatic check_clear_log(input string tag, input logic [7:0] a);
    int bad = 0;
    logic [23:0] exp;
    check_eq({tag, "_cnt"}, wr_q.size(), Bytes);
    for (int i = 0; i < wr_q.size() && i < Bytes; i++) begin
      exp = {16'(16'hF000 + i), (i % 2 == 1) ? a : 8'h20};
      if (wr_q[i] !== exp) bad++;
    end
    check_eq({tag, "_seq"}, bad, 0);
  endtask

  // Called at a negedge; returns at a negedge with in_ready high (or bound hit).
  task automatic wait_ready(input string tag, output int low);
    low = 0;
    while (!bus.in_ready && low < 20000) begin
      @(negedge clock);
      low++;
    end
    if (!bus.in_ready) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  task automatic start_byte(input logic [7:0] b, input logic [7:0] a);
    int dummy;
    wait_ready("start", dummy);
    bus.in_data  = b;
    bus.attr     = a;
    bus.in_valid = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] a, output int low);
    start_byte(b, a);
    wait_ready("send", low);
    model_byte(b, a);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int low;
    int base;
    int copies;
    logic [7:0] b;
    logic [7:0] a;

    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.attr     = 8'h07;

    // 1: reset values, then the power-up clear.
    repeat (3) @(negedge clock);
    check_eq("rst_addr", bus.address, 16'hF000);
    check_eq("rst_data", bus.data_o, 8'h00);
    check_eq("rst_we", bus.we, 1'b0);
    check_eq("rst_ready", bus.in_ready, 1'b0);
    check_eq("rst_x", cur_x, 7'd0);
    check_eq("rst_y", cur_y, 5'd0);
    wr_q.delete();
    reset_n = 1'b1;
    wait_ready("clr", low);
    check_clear_log("clr", 8'h07);
    model_clear(8'h07);
    check_cursor("clr");
    check_eq("clr_idle", busy, 1'b0);

    // 2: one printable byte, write order and latency.
    wr_q.delete();
    send_byte(8'h41, 8'h1E, low);
    check_eq("put_cnt", wr_q.size(), 2);
    check_eq("put_c", wr_q[0], {16'hF000, 8'h41});
    check_eq("put_a", wr_q[1], {16'hF001, 8'h1E});
    check_eq("put_low", low, 3);
    check_cursor("put");

    // 3: BS, CR, LF at (5,3) leave memory alone.
    for (int i = 0; i < 3; i++) send_byte(8'h0A, 8'h1E, low);
    for (int i = 0; i < 4; i++) send_byte(8'h63, 8'h1E, low);
    check_cursor("pos53");
    wr_q.delete();
    send_byte(8'h08, 8'h1E, low);
    check_cursor("bs");
    send_byte(8'h0D, 8'h1E, low);
    check_cursor("cr");
    send_byte(8'h0A, 8'h1E, low);
    check_cursor("lf");
    check_eq("ctl_nowr", wr_q.size(), 0);

    // Random printable/control mix, kept clear of the last rows.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0: b = 8'h0D;
        1: b = 8'h08;
        2: b = (my < 20) ? 8'h0A : 8'h2E;
        default: b = 8'($urandom_range(33, 126));
      endcase
      a = 8'($urandom_range(0, 255));
      wr_q.delete();
      send_byte(b, a, low);
      check_cursor("rnd");
      check_eq("rnd_wr", wr_q.size(), (b > 8'h0D || b == 8'h0B || b < 8'h08) ? 2 : 0);
    end
    check_screen("rnd_scr");

    // Form feed clears with the new attribute.
    wr_q.delete();
    send_byte(8'h0C, 8'h17, low);
    check_clear_log("ff", 8'h17);
    check_cursor("ff");

    // 4: row 1 of 'B', then wrap at the bottom-right corner.
    send_byte(8'h0A, 8'h2F, low);
    for (int i = 0; i < Cols; i++) send_byte(8'h42, 8'h2F, low);
    for (int i = 0; i < Rows - 3; i++) send_byte(8'h0A, 8'h2F, low);
    for (int i = 0; i < Cols - 1; i++) send_byte(8'h79, 8'h2F, low);
    check_cursor("corner");
    wr_q.delete();
    send_byte(8'h5A, 8'h4E, low);
    check_eq("wrap_cnt", wr_q.size(), 2 + 3840 + 160);
    check_eq("wrap_z", wr_q[0], {16'hFF9E, 8'h5A});
    check_eq("wrap_za", wr_q[1], {16'hFF9F, 8'h4E});
    copies = 0;
    foreach (wr_q[i]) if (i >= 2 && wr_q[i][23:8] < 16'hFF00) copies++;
    check_eq("wrap_copies", copies, 3840);
    check_eq("wrap_b", mem[16'hF000], 8'h42);
    check_screen("wrap_scr");
    check_cursor("wrap");

    // 5: in_valid held through an LF scroll.
    base = n_take;
    wr_q.delete();
    wait_ready("hold", low);
    bus.in_data  = 8'h0A;
    bus.attr     = 8'h3C;
    bus.in_valid = 1'b1;
    @(negedge clock);
    bus.in_data = 8'h51;
    check_eq("hold_busy", busy, 1'b1);
    check_eq("hold_ready", bus.in_ready, 1'b0);
    wait_ready("hold_wait", low);
    @(negedge clock);
    bus.in_valid = 1'b0;
    wait_ready("hold_done", low);
    model_byte(8'h0A, 8'h3C);
    model_byte(8'h51, 8'h3C);
    check_eq("hold_takes", n_take - base, 2);
    check_eq("hold_q", wr_q[wr_q.size() - 2], {16'hFF00, 8'h51});
    check_screen("hold_scr");
    check_cursor("hold");

    // 6: reset in the middle of a scroll.
    start_byte(8'h0A, 8'h5B);
    repeat (1000) @(negedge clock);
    reset_n = 1'b0;
    wr_q.delete();
    #1;
    check_eq("abort_we", bus.we, 1'b0);
    check_eq("abort_addr", bus.address, 16'hF000);
    check_eq("abort_ready", bus.in_ready, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_ready("abort_clr", low);
    check_clear_log("abort", 8'h5B);
    model_clear(8'h5B);
    check_screen("abort_scr");
    check_cursor("abort");

    // BS at column 0 does nothing.
    wr_q.delete();
    send_byte(8'h08, 8'h5B, low);
    check_cursor("bs0");
    check_eq("bs0_nowr", wr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
